jt51_exp2lin: RTL and testbench
===============================

Name: jt51_exp2lin

Overview:
- Log-to-linear conversion stage for the operator output path.
- Takes a 13-bit attenuation (sine-log plus envelope sum) with a sign bit, and addresses the 32×45 exponent ROM (one-cycle registered read).
- Decodes the returned packed word into a mantissa, applies the exponent shift and the sign, and delivers a registered signed linear sample to the accumulator.
- Fully pipelined: one sample per clock, fixed latency.

Parameters:
- OUT_W, 14: output width in bits, signed. Must be ≥ 11. Magnitude is left-padded with OUT_W-11 zero LSBs before shifting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_att/in_sign valid this cycle
- in_att  in  13  attenuation: [12:8] shift, [7:3] ROM row, [2:0] sub-index
- in_sign  in  1  1 = negative sample
- in_mute  in  1  forces this sample's output to zero; travels with the sample
- rom_addr  out  5  registered row address to the exponent ROM
- rom_data  in  45  ROM word, valid one clock after rom_addr changes
- out_valid  out  1  out_lin holds a new sample
- out_lin  out  OUT_W  signed two's-complement linear sample

Behaviour:
- Reset (async, rst_n=0):
  - rom_addr=0, out_valid=0, out_lin=0.
  - All internal pipeline valids, sign, mute, shift and sub registers clear.
  - Release is synchronous to the next clk edge.
- Stage A, edge E0:
  - When in_valid=1: rom_addr <= in_att[7:3]. A_valid, A_shift=in_att[12:8], A_sub=in_att[2:0], A_sign and A_mute are captured.
  - When in_valid=0: A_valid <= 0 and rom_addr holds.
- Stage B, edge E1:
  - B_* <= A_* unconditionally.
  - The ROM registers explut[rom_addr] on the same edge, so rom_data aligns with stage B after E1.
- Stage C, edge E2, output stage:
  - Field select: f0=rom_data[44:36], f1=[35:27], f2=[26:18], f3=[17:9], f4=[8:0]. B_sub 0..4 selects f0..f4; B_sub 5, 6 and 7 select f4.
  - mant = {1'b1, field}, 10 bits, range 512..1023.
  - mag = {mant, (OUT_W-11) zeros} >> B_shift, logical shift. Any B_shift ≥ OUT_W-1 gives mag=0, so there is no wrap.
  - If B_mute=1 or mag=0: out_lin <= 0, and the sign is ignored, so no negative zero.
  - Otherwise out_lin <= B_sign ? -mag : +mag. Full OUT_W arithmetic, no overflow possible since |mag| ≤ 2^(OUT_W-1)-8.
  - out_valid <= B_valid.
  - out_lin updates only when B_valid=1; otherwise it holds its previous value.
- Latency and throughput:
  - Latency is exactly 3 clk edges: sampled at E0, out_valid high after E2.
  - Throughput is 1 per clock; back-to-back samples never interact.
- Bubbles: in_valid gaps propagate as out_valid=0 gaps in the same positions.
- Reset mid-operation: all in-flight samples are discarded, and no out_valid pulse occurs for them after release.
- No backpressure: the consumer must accept every out_valid cycle.

Test Plan:
- Reset with rst_n=0 for 3 cycles, toggling inputs during reset -> rom_addr=0, out_valid=0, out_lin=0 throughout reset, and no out_valid after release until a sample enters.
- Single sample att=13'h0000, sign=0, mute=0, ROM row 0 f0=9'h1F5 -> rom_addr=0 after E0; out_valid pulses exactly one cycle after E2; out_lin=+8104 (OUT_W=14).
- att=13'h0004 (sub 4, f4=9'h1DB), then the same with sign=1 -> +7896 followed by -7896 on consecutive cycles.
- Stream att rows 0..31, sub 0, shift 0, back-to-back -> 32 consecutive out_valid cycles. Each output equals (512+f0[row])*8 from the ROM model (row 31: +5584). in_valid gaps inserted mid-stream reappear with the same spacing.
- Edge cases, each checked separately:
  - shift=13 -> out_lin=0 with sign=1 (no negative zero).
  - shift=31 -> out_lin=0.
  - sub=7 -> f4 selected.
  - in_mute=1 -> 0 despite valid data.
- Assert rst_n low for 1 cycle while 3 samples are in flight -> none emerge, and a sample issued 1 cycle after release appears with normal 3-cycle latency.

Source files
------------

// File: rtl/jt51_exp2lin.sv
// Log-to-linear conversion for the operator output: attenuation -> exponent ROM
// row lookup -> mantissa shift and sign -> registered signed linear sample.
module jt51_exp2lin #(
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [12:0]      in_att,
  input  logic             in_sign,
  input  logic             in_mute,
  output logic [4:0]       rom_addr,
  input  logic [44:0]      rom_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_lin
);

  localparam int PAD = OUT_W - 11;

  // [0] stage A, [1] stage B (aligned with rom_data), [2] output
  logic [2:0] vld_pipe;
  logic [4:0] a_shift, b_shift;
  logic [2:0] a_sub, b_sub;
  logic       a_sign, b_sign, a_mute, b_mute;

  logic [8:0]       field;
  logic [OUT_W-2:0] ext, mag;
  logic [OUT_W-1:0] lin_next;

  assign out_valid = vld_pipe[2];

  always_comb begin
    field = rom_data[8:0];
    case (b_sub)
      3'd0:    field = rom_data[44:36];
      3'd1:    field = rom_data[35:27];
      3'd2:    field = rom_data[26:18];
      3'd3:    field = rom_data[17:9];
      default: field = rom_data[8:0];
    endcase
  end

  // Mantissa always has its hidden 1, so only mute or a full shift-out gives zero.
  assign ext = (OUT_W-1)'({1'b1, field}) << PAD;
  assign mag = (int'(b_shift) >= OUT_W-1) ? '0 : (ext >> b_shift);

  always_comb begin
    lin_next = '0;
    if (!b_mute && mag != '0)
      lin_next = b_sign ? -{1'b0, mag} : {1'b0, mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rom_addr <= '0;
      a_shift  <= '0;
      a_sub    <= '0;
      a_sign   <= 1'b0;
      a_mute   <= 1'b0;
      b_shift  <= '0;
      b_sub    <= '0;
      b_sign   <= 1'b0;
      b_mute   <= 1'b0;
      out_lin  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], in_valid};
      if (in_valid) begin
        rom_addr <= in_att[7:3];
        a_shift  <= in_att[12:8];
        a_sub    <= in_att[2:0];
        a_sign   <= in_sign;
        a_mute   <= in_mute;
      end
      b_shift <= a_shift;
      b_sub   <= a_sub;
      b_sign  <= a_sign;
      b_mute  <= a_mute;
      if (vld_pipe[1])
        out_lin <= lin_next;
    end
  end

endmodule

// File: tb/tb_jt51_exp2lin.sv
// Directed-vector bench for jt51_exp2lin with a registered exponent ROM model.
module tb_jt51_exp2lin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] in_att;
  logic        in_sign;
  logic        in_mute;
  logic [4:0]  rom_addr;
  logic [44:0] rom_data = '0;
  logic        out_valid;
  logic [13:0] out_lin;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt51_exp2lin #(.OUT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_att(in_att),
    .in_sign(in_sign), .in_mute(in_mute), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_lin(out_lin)
  );

  // ROM contents: row 0 f0=1F5 f4=1DB, row 31 f0=0BA; other rows synthetic.
  function automatic int f0_of(input int r);
    return (r == 31) ? 186 : 501 - r * 10;
  endfunction

  function automatic logic [44:0] rom_word(input logic [4:0] r);
    int f0;
    logic [8:0] f [5];
    f0 = f0_of(int'(r));
    for (int k = 0; k < 4; k++) f[k] = 9'(f0 - 6 * k);
    f[4] = 9'(f0 - 26);
    return {f[0], f[1], f[2], f[3], f[4]};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    logic        v;
    logic [12:0] att;
    logic        sign;
    logic        mute;
    logic        ev;
    int          el;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   held;

  task automatic add(input logic v, input logic [12:0] att, input logic sign,
                     input logic mute, input int el);
    vecs[nvec].v    = v;
    vecs[nvec].att  = att;
    vecs[nvec].sign = sign;
    vecs[nvec].mute = mute;
    vecs[nvec].ev   = v;
    vecs[nvec].el   = el;
    nvec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    in_valid = t.v;
    in_att   = t.att;
    in_sign  = t.sign;
    in_mute  = t.mute;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_att = '0; in_sign = 1'b0; in_mute = 1'b0;

    // single / sign pair / sub-index / shift / mute edge cases
    add(1, 13'h0000, 0, 0, 8104);
    add(0, 13'h0000, 0, 0, 0);
    add(1, 13'h0004, 0, 0, 7896);
    add(1, 13'h0004, 1, 0, -7896);
    add(1, 13'h0001, 0, 0, 8056);
    add(1, 13'h0002, 0, 0, 8008);
    add(1, 13'h0003, 0, 0, 7960);
    add(1, 13'h0007, 0, 0, 7896);
    add(1, 13'h0100, 1, 0, -4052);
    add(1, 13'h0300, 0, 0, 1013);
    add(1, 13'h0C00, 1, 0, -1);
    add(1, 13'h0D00, 1, 0, 0);
    add(1, 13'h022B, 0, 0, 1890);
    add(1, 13'h1F00, 0, 0, 0);
    add(1, 13'h0000, 1, 1, 0);
    add(1, 13'h00F8, 1, 0, -5584);
    // row sweep with bubbles
    for (int r = 0; r < 32; r++) begin
      add(1, 13'(r << 3), 0, 0, (512 + f0_of(r)) * 8);
      if (r == 10) add(0, 13'h1FFF, 1, 0, 0);
      if (r == 20) begin
        add(0, 13'h0000, 0, 0, 0);
        add(0, 13'h0000, 0, 0, 0);
      end
    end

    // reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b1;
      in_att   = 13'h1ABC ^ 13'(i);
      in_sign  = ~in_sign;
      in_mute  = i[0];
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_lin", int'(out_lin), 0);
    end
    in_valid = 1'b0; in_sign = 1'b0; in_mute = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_after_rst", int'(out_valid), 0);
    end

    // first sample: address and latency
    in_valid = 1'b1; in_att = 13'h022B;
    tick();
    chk("rom_addr_e0", int'(rom_addr), 5);
    in_valid = 1'b0;
    tick();
    chk("lat_e1_valid", int'(out_valid), 0);
    tick();
    chk("lat_e2_valid", int'(out_valid), 1);
    chk("lat_e2_lin", int'($signed(out_lin)), 1890);
    held = 1890;

    // table run
    for (int c = 0; c < nvec + 2; c++) begin
      if (c < nvec) drive(vecs[c]);
      else begin
        in_valid = 1'b0; in_att = '0; in_sign = 1'b0; in_mute = 1'b0;
      end
      tick();
      if (c >= 2) begin
        chk($sformatf("vec%0d_valid", c - 2), int'(out_valid), int'(vecs[c-2].ev));
        if (vecs[c-2].ev) held = vecs[c-2].el;
        chk($sformatf("vec%0d_lin", c - 2), int'($signed(out_lin)), held);
      end
    end
    in_valid = 1'b0;

    // reset with samples in flight
    in_valid = 1'b1; in_att = 13'h0000; in_sign = 1'b0;
    tick();
    in_att = 13'h0004;
    tick();
    in_att = 13'h0100;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_lin", int'(out_lin), 0);
    tick();
    chk("midrst_e3_valid", int'(out_valid), 0);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst_e4_valid", int'(out_valid), 0);
    in_valid = 1'b1; in_att = 13'h022B; in_sign = 1'b1;
    tick();
    chk("post_rst_e5_valid", int'(out_valid), 0);
    in_valid = 1'b0; in_sign = 1'b0;
    tick();
    chk("post_rst_e6_valid", int'(out_valid), 0);
    tick();
    chk("post_rst_e7_valid", int'(out_valid), 1);
    chk("post_rst_e7_lin", int'($signed(out_lin)), -1890);
    tick();
    chk("post_rst_e8_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
